mul_hilo_ctrl: RTL and testbench

Sequencer for the integer multiply unit and the HI/LO result registers. It accepts MULTU/MADDU issues from the execute stage and runs a 32-cycle shift-add multiply. It then commits the 64-bit result to HI/LO, either overwriting (MULTU) or accumulating (MADDU), and serves MFHI/MFLO reads. It stalls the pipeline for any issue or read that arrives while an operation is in flight.

---
 rtl/mul_hilo_ctrl_if.sv | 30 +++
 rtl/mul_hilo_ctrl.sv | 129 ++++++++++++
 tb/tb_mul_hilo_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_hilo_ctrl_if.sv
// Issue, read and status bundle between the execute stage and the multiply/HI-LO sequencer.
interface mul_hilo_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             mf_req;
  logic             mf_sel;
  logic             busy;
  logic             stall;
  logic             done;
  logic             mf_valid;
  logic [WIDTH-1:0] mf_data;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  // Execute stage side: drives issues and reads, observes status.
  modport master (
    output start, op, rs, rt, mf_req, mf_sel,
    input  busy, stall, done, mf_valid, mf_data, hi_out, lo_out
  );

  // Sequencer side.
  modport slave (
    input  start, op, rs, rt, mf_req, mf_sel,
    output busy, stall, done, mf_valid, mf_data, hi_out, lo_out
  );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// Multiply sequencer with HI/LO result registers: 32-step shift-add unsigned
// multiply, commit by overwrite (MULTU) or accumulate (MADDU), and MFHI/MFLO reads.
module mul_hilo_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mul_hilo_ctrl_if.slave bus
);
  localparam logic [5:0] MULTU = 6'd25;
  localparam logic [5:0] MADDU = 6'd1;
  localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL    = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t               r_state;
  logic [5:0]           r_cnt;
  logic [2*WIDTH:0]     r_prod;
  logic [WIDTH-1:0]     r_mcand;
  logic                 r_opq;
  logic [2*WIDTH-1:0]   r_hilo;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_mf_valid;
  logic [WIDTH-1:0]     r_mf_data;

  logic [WIDTH:0]       w_upper;
  logic [2*WIDTH:0]     w_prod_next;
  logic                 w_is_mul;

  // One shift-add step: conditionally add the multiplicand into the upper half, then shift right.
  always_comb begin
    w_upper     = r_prod[2*WIDTH:WIDTH];
    w_prod_next = r_prod;
    w_is_mul    = 1'b0;
    if (r_prod[0]) begin
      w_upper = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    end else begin
      w_upper = r_prod[2*WIDTH:WIDTH];
    end
    w_prod_next = {1'b0, w_upper, r_prod[WIDTH-1:1]};
    w_is_mul    = bus.start & ((bus.op == MULTU) | (bus.op == MADDU));
  end

  // Sequencer FSM: issue in IDLE, WIDTH iterations in MUL, HI/LO update in COMMIT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 6'd0;
      r_prod  <= '0;
      r_mcand <= '0;
      r_opq   <= 1'b0;
      r_hilo  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_is_mul) begin
            r_mcand <= bus.rs;
            r_prod  <= {{(WIDTH+1){1'b0}}, bus.rt};
            r_cnt   <= 6'd0;
            r_opq   <= (bus.op == MADDU);
            r_busy  <= 1'b1;
            r_state <= ST_MUL;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          r_prod <= w_prod_next;
          r_cnt  <= r_cnt + 6'd1;
          r_busy <= 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_done  <= 1'b1;
            r_state <= ST_COMMIT;
          end else begin
            r_done  <= 1'b0;
            r_state <= ST_MUL;
          end
        end
        ST_COMMIT: begin
          // Accumulate wraps modulo 2^(2*WIDTH); the carry out is dropped.
          if (r_opq) begin
            r_hilo <= r_hilo + r_prod[2*WIDTH-1:0];
          end else begin
            r_hilo <= r_prod[2*WIDTH-1:0];
          end
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // MFHI/MFLO read port: served only in IDLE, so a read sees HI/LO before any same-cycle issue.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mf_valid <= 1'b0;
      r_mf_data  <= '0;
    end else if ((r_state == ST_IDLE) && bus.mf_req) begin
      r_mf_valid <= 1'b1;
      r_mf_data  <= bus.mf_sel ? r_hilo[2*WIDTH-1:WIDTH] : r_hilo[WIDTH-1:0];
    end else begin
      r_mf_valid <= 1'b0;
      r_mf_data  <= r_mf_data;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.stall    = r_busy & (bus.start | bus.mf_req);
  assign bus.done     = r_done;
  assign bus.mf_valid = r_mf_valid;
  assign bus.mf_data  = r_mf_data;
  assign bus.hi_out   = r_hilo[2*WIDTH-1:WIDTH];
  assign bus.lo_out   = r_hilo[WIDTH-1:0];
endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl with scoreboards for commits and reads.
module tb_mul_hilo_ctrl;
  localparam logic [5:0] MULTU = 6'd25;
  localparam logic [5:0] MADDU = 6'd1;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [63:0] q_hilo[$];
  logic [31:0] q_rd[$];
  logic [63:0] m_hilo;
  logic [63:0] m_com;

  mul_hilo_ctrl_if #(.WIDTH(32)) bus_if ();

  mul_hilo_ctrl #(.WIDTH(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; score any commit or read that the edge completes.
  task automatic tick();
    logic d, rd, bsy, sel, r;
    logic [63:0] e;
    d   = bus_if.done;
    rd  = bus_if.mf_req;
    bsy = bus_if.busy;
    sel = bus_if.mf_sel;
    r   = rst;
    if (!r && rd && !bsy) q_rd.push_back(sel ? m_com[63:32] : m_com[31:0]);
    @(posedge clk);
    #1;
    if (!r) begin
      if (d === 1'b1) begin
        if (q_hilo.size() == 0) begin
          chk("unexpected_commit", 64'd1, 64'd0);
        end else begin
          e = q_hilo.pop_front();
          m_com = e;
          chk("hilo", {bus_if.hi_out, bus_if.lo_out}, e);
          chk("busy_after_commit", {63'd0, bus_if.busy}, 64'd0);
        end
      end
      if (rd && !bsy) begin
        chk("mf_valid", {63'd0, bus_if.mf_valid}, 64'd1);
        chk("mf_data", {32'd0, bus_if.mf_data}, {32'd0, q_rd.pop_front()});
      end else if (rd) begin
        chk("mf_valid_while_busy", {63'd0, bus_if.mf_valid}, 64'd0);
      end else begin
        chk("mf_valid_idle", {63'd0, bus_if.mf_valid}, 64'd0);
      end
    end
  endtask

  // Present an issue and hold it until accepted; push the expected HI/LO.
  task automatic issue(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt);
    int n;
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.rs    = rs;
    bus_if.rt    = rt;
    n = 0;
    while (bus_if.busy && n < 100) begin
      #1;
      chk("stall_start_busy", {63'd0, bus_if.stall}, 64'd1);
      tick();
      n++;
    end
    if (n >= 100) chk("issue_timeout", 64'd1, 64'd0);
    #1;
    chk("stall_idle", {63'd0, bus_if.stall}, 64'd0);
    tick();
    bus_if.start = 1'b0;
    chk("busy_after_issue", {63'd0, bus_if.busy}, 64'd1);
    if (op == MULTU) m_hilo = 64'(rs) * 64'(rt);
    else             m_hilo = m_hilo + 64'(rs) * 64'(rt);
    q_hilo.push_back(m_hilo);
  endtask

  // Wait for done (expected 32 edges after the issue edge), then let the commit be scored.
  task automatic wait_commit();
    int k;
    k = 0;
    while (bus_if.done !== 1'b1 && k < 40) begin
      chk("done_early", {63'd0, bus_if.done}, 64'd0);
      tick();
      k++;
    end
    chk("done_latency", 64'(k), 64'd32);
    tick();
    chk("done_pulse_width", {63'd0, bus_if.done}, 64'd0);
  endtask

  task automatic mf_read(input logic sel);
    bus_if.mf_req = 1'b1;
    bus_if.mf_sel = sel;
    tick();
    bus_if.mf_req = 1'b0;
    tick();
  endtask

  initial begin
    int   n;
    logic seen;
    n_tests = 0;
    n_fail  = 0;
    m_hilo  = 64'd0;
    m_com   = 64'd0;
    rst = 1'b1;
    bus_if.start  = 1'b0;
    bus_if.op     = 6'd0;
    bus_if.rs     = 32'd0;
    bus_if.rt     = 32'd0;
    bus_if.mf_req = 1'b0;
    bus_if.mf_sel = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", {63'd0, bus_if.busy}, 64'd0);
    chk("rst_stall", {63'd0, bus_if.stall}, 64'd0);
    chk("rst_done", {63'd0, bus_if.done}, 64'd0);
    chk("rst_mf_valid", {63'd0, bus_if.mf_valid}, 64'd0);
    chk("rst_mf_data", {32'd0, bus_if.mf_data}, 64'd0);
    chk("rst_hilo", {bus_if.hi_out, bus_if.lo_out}, 64'd0);

    // Reads after reset, including back-to-back continuous requests.
    mf_read(1'b0);
    bus_if.mf_req = 1'b1;
    bus_if.mf_sel = 1'b1;
    repeat (2) tick();
    bus_if.mf_req = 1'b0;
    tick();

    // Illegal op leaves the sequencer idle.
    bus_if.start = 1'b1;
    bus_if.op    = 6'd7;
    bus_if.rs    = 32'd5;
    bus_if.rt    = 32'd6;
    tick();
    bus_if.start = 1'b0;
    chk("bad_op_busy", {63'd0, bus_if.busy}, 64'd0);

    // Full-scale MULTU.
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_commit();
    chk("max_hi", {32'd0, bus_if.hi_out}, 64'h0000_0000_FFFF_FFFE);
    chk("max_lo", {32'd0, bus_if.lo_out}, 64'h0000_0000_0000_0001);
    mf_read(1'b1);

    // Overwrite then accumulate.
    issue(MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_commit();
    issue(MADDU, 32'd3, 32'd5);
    wait_commit();
    chk("acc_lo", {32'd0, bus_if.lo_out}, 64'h0000_0000_0000_000F);

    // Carry from LO into HI, then a true 2^64 wrap.
    issue(MULTU, 32'd1, 32'hFFFF_FFFF);
    wait_commit();
    issue(MADDU, 32'hFFFF_FFFF, 32'd1);
    wait_commit();
    chk("carry_hilo", {bus_if.hi_out, bus_if.lo_out}, 64'h0000_0001_FFFF_FFFE);
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_commit();
    issue(MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_commit();
    chk("wrap_hilo", {bus_if.hi_out, bus_if.lo_out}, 64'hFFFF_FFFC_0000_0002);

    // MFHI raised mid-operation: stalled until idle, then returns post-commit HI.
    issue(MULTU, 32'd7, 32'd9);
    repeat (5) tick();
    bus_if.mf_req = 1'b1;
    bus_if.mf_sel = 1'b1;
    n = 0;
    while (bus_if.busy && n < 60) begin
      #1;
      chk("stall_mf_busy", {63'd0, bus_if.stall}, 64'd1);
      tick();
      n++;
    end
    #1;
    chk("stall_mf_idle", {63'd0, bus_if.stall}, 64'd0);
    tick();
    chk("hazard_mf_data", {32'd0, bus_if.mf_data}, 64'd0);
    bus_if.mf_req = 1'b0;
    tick();

    // Issue held while busy is taken on the first idle cycle.
    issue(MULTU, 32'd6, 32'd7);
    issue(MADDU, 32'd100, 32'd3);
    wait_commit();
    chk("held_lo", {32'd0, bus_if.lo_out}, 64'd342);

    // Issue and read in the same idle cycle: read sees pre-operation LO.
    bus_if.mf_req = 1'b1;
    bus_if.mf_sel = 1'b0;
    issue(MULTU, 32'd2, 32'd2);
    bus_if.mf_req = 1'b0;
    chk("rbw_mf_data", {32'd0, bus_if.mf_data}, 64'd342);
    wait_commit();

    // Reset in the middle of an operation discards it.
    issue(MULTU, 32'd3, 32'd4);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_hilo.delete();
    m_hilo = 64'd0;
    m_com  = 64'd0;
    chk("midrst_busy", {63'd0, bus_if.busy}, 64'd0);
    chk("midrst_hilo", {bus_if.hi_out, bus_if.lo_out}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.done === 1'b1) seen = 1'b1;
      tick();
    end
    chk("midrst_no_done", {63'd0, seen}, 64'd0);
    issue(MULTU, 32'd3, 32'd4);
    wait_commit();
    chk("post_rst_lo", {32'd0, bus_if.lo_out}, 64'd12);
    chk("hilo_queue_empty", 64'(q_hilo.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
